// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined RV32 control unit:
// opcodes, control-word bit positions, lsize codes, FSM states.
package ctrl_pkg;

    localparam int CW_W = 16;

    // Control-word bit positions
    localparam int CW_ILLEGAL   = 15;
    localparam int CW_FENCE     = 14;
    localparam int CW_HALT      = 13;
    localparam int CW_JALR      = 12;
    localparam int CW_LSIZE     = 9;
    localparam int CW_BRANCH    = 8;
    localparam int CW_MEMREAD   = 7;
    localparam int CW_MEMTOREG  = 6;
    localparam int CW_ALUOP     = 4;
    localparam int CW_MEMWRITE  = 3;
    localparam int CW_ALUSRC    = 2;
    localparam int CW_REGWRITE  = 1;
    localparam int CW_JUMPWRITE = 0;

    // Opcodes, instruction[6:2]
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // ALU op field
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_RI  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    // Load/store size codes
    localparam logic [2:0] LS_W  = 3'b000;
    localparam logic [2:0] LS_B  = 3'b001;
    localparam logic [2:0] LS_H  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b011;
    localparam logic [2:0] LS_HU = 3'b100;

    // FSM states
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_HALTPEND = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32 instruction -> 16-bit control word.
// Ports: i_instr (raw word), o_cw (control word, 0x8000 if illegal).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr,
    output logic [CW_W-1:0] o_cw
);

    logic [4:0]      w_op;
    logic [2:0]      w_f3;
    logic            w_bad;
    logic [CW_W-1:0] w_cw;
    logic            w_unused;

    assign w_op     = i_instr[6:2];
    assign w_f3     = i_instr[14:12];
    assign w_unused = ^{i_instr[XLEN-1:15], i_instr[11:7]};

    always_comb begin
        w_cw  = '0;
        w_bad = 1'b0;
        case (w_op)
            OP_R: begin
                w_cw[CW_ALUOP+:2]   = ALU_RI;
                w_cw[CW_REGWRITE]   = 1'b1;
            end
            OP_I: begin
                w_cw[CW_ALUOP+:2]   = ALU_RI;
                w_cw[CW_ALUSRC]     = 1'b1;
                w_cw[CW_REGWRITE]   = 1'b1;
            end
            OP_LOAD: begin
                w_cw[CW_MEMREAD]    = 1'b1;
                w_cw[CW_MEMTOREG]   = 1'b1;
                w_cw[CW_ALUSRC]     = 1'b1;
                w_cw[CW_REGWRITE]   = 1'b1;
                case (w_f3)
                    3'b010:  w_cw[CW_LSIZE+:3] = LS_W;
                    3'b000:  w_cw[CW_LSIZE+:3] = LS_B;
                    3'b001:  w_cw[CW_LSIZE+:3] = LS_H;
                    3'b100:  w_cw[CW_LSIZE+:3] = LS_BU;
                    3'b101:  w_cw[CW_LSIZE+:3] = LS_HU;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_cw[CW_MEMWRITE]   = 1'b1;
                w_cw[CW_ALUSRC]     = 1'b1;
                case (w_f3)
                    3'b010:  w_cw[CW_LSIZE+:3] = LS_W;
                    3'b000:  w_cw[CW_LSIZE+:3] = LS_B;
                    3'b001:  w_cw[CW_LSIZE+:3] = LS_H;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                w_cw[CW_BRANCH]     = 1'b1;
                w_cw[CW_ALUOP+:2]   = ALU_BR;
            end
            OP_JAL: begin
                w_cw[CW_JUMPWRITE]  = 1'b1;
                w_cw[CW_REGWRITE]   = 1'b1;
            end
            OP_JALR: begin
                w_cw[CW_JALR]       = 1'b1;
                w_cw[CW_JUMPWRITE]  = 1'b1;
                w_cw[CW_ALUSRC]     = 1'b1;
                w_cw[CW_REGWRITE]   = 1'b1;
            end
            OP_LUI: begin
                w_cw[CW_ALUOP+:2]   = ALU_LUI;
                w_cw[CW_ALUSRC]     = 1'b1;
                w_cw[CW_REGWRITE]   = 1'b1;
            end
            OP_AUIPC: begin
                w_cw[CW_ALUOP+:2]   = ALU_ADD;
                w_cw[CW_ALUSRC]     = 1'b1;
                w_cw[CW_REGWRITE]   = 1'b1;
                w_cw[CW_JUMPWRITE]  = 1'b1;
            end
            OP_FENCE:  w_cw[CW_FENCE] = 1'b1;
            OP_SYSTEM: w_cw[CW_HALT]  = 1'b1;
            default:   w_bad = 1'b1;
        endcase
        // Illegal words collapse to a lone illegal flag so nothing writes.
        if (w_bad || i_instr[1:0] != 2'b11) begin
            w_cw             = '0;
            w_cw[CW_ILLEGAL] = 1'b1;
        end
    end

    assign o_cw = w_cw;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decode, STAGES CW slots, stall/flush, FENCE/HALT FSM.
// Ports: in_valid/instruction/in_ready in, stall/flush, id_cw, cw_pipe/vld_pipe, halted, fence_busy.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STAGES      = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [XLEN-1:0]        instruction,
    output logic                   in_ready,
    input  logic                   stall,
    input  logic                   flush,
    output logic [CW_W-1:0]        id_cw,
    output logic [CW_W*STAGES-1:0] cw_pipe,
    output logic [STAGES-1:0]      vld_pipe,
    output logic                   halted,
    output logic                   fence_busy
);

    logic [STAGES-1:0][CW_W-1:0] r_cw;
    logic [STAGES-1:0]           r_vld;
    logic [1:0]                  r_state;

    logic [STAGES-1:0][CW_W-1:0] w_nxt_cw;
    logic [STAGES-1:0]           w_nxt_vld;
    logic [1:0]                  w_state_nxt;
    logic                        w_accept;
    logic                        w_fence_young;
    logic                        w_halt_young;
    logic                        w_halt_last;

    ctrl_decode #(.XLEN(XLEN)) u_dec (
        .i_instr (instruction),
        .o_cw    (id_cw)
    );

    assign in_ready   = (r_state == ST_RUN);
    assign fence_busy = (r_state == ST_DRAIN);
    assign halted     = (r_state == ST_HALTED);
    assign w_accept   = in_valid & in_ready & ~stall & ~flush;
    assign cw_pipe    = r_cw;
    assign vld_pipe   = r_vld;

    // Next slot contents; invalid slots always carry CW = 0.
    always_comb begin
        w_nxt_cw  = '0;
        w_nxt_vld = '0;
        if (w_accept) begin
            w_nxt_cw[0]  = id_cw;
            w_nxt_vld[0] = 1'b1;
        end else if (stall && !flush) begin
            w_nxt_cw[0]  = r_cw[0];
            w_nxt_vld[0] = r_vld[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (!(stall && !flush && k == 1)) begin
                w_nxt_cw[k]  = r_cw[k-1];
                w_nxt_vld[k] = r_vld[k-1];
            end
        end
        if (flush) begin
            for (int k = 0; k < FLUSH_DEPTH; k++) begin
                w_nxt_cw[k]  = '0;
                w_nxt_vld[k] = 1'b0;
            end
        end
    end

    // Track whether the pending FENCE/HALT is still in flight ahead of the last slot.
    always_comb begin
        w_fence_young = 1'b0;
        w_halt_young  = 1'b0;
        for (int k = 0; k < STAGES - 1; k++) begin
            w_fence_young = w_fence_young | (w_nxt_vld[k] & w_nxt_cw[k][CW_FENCE]);
            w_halt_young  = w_halt_young  | (w_nxt_vld[k] & w_nxt_cw[k][CW_HALT]);
        end
        w_halt_last = w_nxt_vld[STAGES-1] & w_nxt_cw[STAGES-1][CW_HALT];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_accept && id_cw[CW_FENCE])
                    w_state_nxt = ST_DRAIN;
                else if (w_accept && id_cw[CW_HALT])
                    w_state_nxt = ST_HALTPEND;
            end
            // Leaves when the FENCE reaches the last slot or was flushed.
            ST_DRAIN: begin
                if (!w_fence_young)
                    w_state_nxt = ST_RUN;
            end
            ST_HALTPEND: begin
                if (w_halt_last)
                    w_state_nxt = ST_HALTED;
                else if (!w_halt_young)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cw    <= '0;
            r_vld   <= '0;
            r_state <= ST_RUN;
        end else begin
            r_cw    <= w_nxt_cw;
            r_vld   <= w_nxt_vld;
            r_state <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed scoreboard bench for ctrl_pipe_unit (STAGES=3, FLUSH_DEPTH=2).
// Expected CWs are queued on drive and popped when a slot-2 entry retires.
module tb_ctrl_pipe_unit;

    localparam int S  = 3;
    localparam int NT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   instruction;
    logic          in_ready;
    logic          stall;
    logic          flush;
    logic [15:0]   id_cw;
    logic [16*S-1:0] cw_pipe;
    logic [S-1:0]  vld_pipe;
    logic          halted;
    logic          fence_busy;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb[$];

    logic [31:0] t_in [NT] = '{
        32'h00112023, 32'h00110023, 32'h00111023, 32'h00000063,
        32'h0000006F, 32'h00008067, 32'h000000B7, 32'h00000097,
        32'h00015083, 32'h00014083, 32'h00011083, 32'h00003083,
        32'h00113023, 32'h0000007F, 32'h00000001
    };
    logic [15:0] t_cw [NT] = '{
        16'h000C, 16'h020C, 16'h040C, 16'h0110,
        16'h0003, 16'h1007, 16'h0036, 16'h0007,
        16'h08C6, 16'h06C6, 16'h04C6, 16'h8000,
        16'h8000, 16'h8000, 16'h8000
    };

    ctrl_pipe_unit #(.XLEN(32), .STAGES(S), .FLUSH_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .id_cw       (id_cw),
        .cw_pipe     (cw_pipe),
        .vld_pipe    (vld_pipe),
        .halted      (halted),
        .fence_busy  (fence_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < S; k++)
            if (!vld_pipe[k])
                chk("bubble_cw_zero", {16'h0, cw_pipe[16*k +: 16]}, 32'h0);
        if (vld_pipe[S-1]) begin
            if (sb.size() == 0)
                chk("sb_underflow", sb.size(), 1);
            else
                chk("retire_cw", {16'h0, cw_pipe[16*(S-1) +: 16]},
                    {16'h0, sb.pop_front()});
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [15:0] exp);
        instruction = ins;
        in_valid    = 1'b1;
        #1;
        chk("id_cw", {16'h0, id_cw}, {16'h0, exp});
        sb.push_back(exp);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instruction = '0;
        stall = 1'b0; flush = 1'b0;
        #12;
        chk("rst_vld", vld_pipe, 0);
        chk("rst_cw", cw_pipe, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_halted", halted, 0);
        chk("rst_fence", fence_busy, 0);
        rst_n = 1'b1;

        // lw, add, addi back to back
        drive(32'h00012083, 16'h00C6);
        step();
        chk("slot0_lw", cw_pipe[15:0], 16'h00C6);
        drive(32'h002081B3, 16'h0022);
        step();
        drive(32'h00100093, 16'h0026);
        step();
        chk("slot2_lw", cw_pipe[47:32], 16'h00C6);
        chk("vld_111", vld_pipe, 3'b111);
        in_valid = 1'b0;
        repeat (3) step();
        chk("drained", vld_pipe, 0);

        // stall: slot0 holds, bubble into slot1
        drive(32'h00010083, 16'h02C6);
        step();
        in_valid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_hold", cw_pipe[15:0], 16'h02C6);
            chk("stall_vld", vld_pipe, 3'b001);
        end
        stall = 1'b0;
        step();
        chk("stall_rel", cw_pipe[31:16], 16'h02C6);
        chk("stall_rel_vld", vld_pipe, 3'b010);
        repeat (2) step();

        // decode table streamed through the pipe
        for (int i = 0; i < NT; i++) begin
            drive(t_in[i], t_cw[i]);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // FENCE drain with a younger instruction waiting
        drive(32'h0000000F, 16'h4000);
        step();
        chk("fence_busy0", fence_busy, 1);
        chk("fence_ready0", in_ready, 0);
        chk("fence_slot0", cw_pipe[15:0], 16'h4000);
        instruction = 32'h002081B3;
        step();
        chk("fence_busy1", fence_busy, 1);
        chk("fence_vld1", vld_pipe, 3'b010);
        step();
        chk("fence_done", fence_busy, 0);
        chk("fence_ready", in_ready, 1);
        chk("fence_slot2", cw_pipe[47:32], 16'h4000);
        sb.push_back(16'h0022);
        step();
        chk("post_fence_acc", cw_pipe[15:0], 16'h0022);
        chk("post_fence_vld", vld_pipe, 3'b001);
        in_valid = 1'b0;
        repeat (3) step();

        // flush with (add, lw, add) in flight
        drive(32'h002081B3, 16'h0022);
        step();
        drive(32'h00012083, 16'h00C6);
        step();
        drive(32'h002081B3, 16'h0022);
        step();
        flush = 1'b1;
        instruction = 32'h00012083;
        void'(sb.pop_back());
        step();
        chk("flush_vld", vld_pipe, 3'b100);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_empty", vld_pipe, 0);

        // illegal all-zero word is a valid non-writing bubble
        drive(32'h00000000, 16'h8000);
        step();
        chk("ill_vld", vld_pipe[0], 1);
        chk("ill_regwrite", cw_pipe[1], 0);
        chk("ill_memwrite", cw_pipe[3], 0);
        in_valid = 1'b0;
        repeat (3) step();

        // HALT, then keep offering instructions
        drive(32'h00000073, 16'h2000);
        step();
        chk("halt_ready", in_ready, 0);
        chk("halt_pend", halted, 0);
        instruction = 32'h002081B3;
        step();
        chk("halt_pend1", halted, 0);
        step();
        chk("halted", halted, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_sticky", halted, 1);
            chk("halt_no_acc", vld_pipe, 0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst", halted, 0);
        chk("halt_rst_ready", in_ready, 1);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // asynchronous reset in the middle of a drain
        drive(32'h0000000F, 16'h4000);
        step();
        chk("drain_busy", fence_busy, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("drain_rst_busy", fence_busy, 0);
        chk("drain_rst_vld", vld_pipe, 0);
        chk("drain_rst_cw", cw_pipe, 0);
        sb.delete();
        rst_n = 1'b1;
        step();
        chk("drain_rst_ready", in_ready, 1);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
